nibbler_sequencer: RTL and testbench

NIBBLER_SEQUENCER -- requirements
Module: nibbler_sequencer

---
 rtl/nibbler_pkg.sv | 61 ++++++
 rtl/nibbler_decoder.sv | 83 ++++++++
 rtl/nibbler_sequencer.sv | 124 ++++++++++++
 tb/tb_nibbler_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// -----------------------------------------------------------------------------
// nibbler_pkg
// Shared types for the Nibbler 4-bit CPU control path: the opcode map, the
// sequencer state encoding, ALU select codes and the decoded control word
// (active-high internally; the top converts to the board's active-low pins).
// Build option: NIBBLER_SINGLE_STEP_EN adds the PAUSE state.
// -----------------------------------------------------------------------------
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC    = 4'h0,
    OP_JNC   = 4'h1,
    OP_CMPI  = 4'h2,
    OP_CMPM  = 4'h3,
    OP_LIT   = 4'h4,
    OP_IN    = 4'h5,
    OP_LD    = 4'h6,
    OP_ST    = 4'h7,
    OP_JZ    = 4'h8,
    OP_JNZ   = 4'h9,
    OP_ADDI  = 4'hA,
    OP_ADDM  = 4'hB,
    OP_JMP   = 4'hC,
    OP_OUT   = 4'hD,
    OP_NANDI = 4'hE,
    OP_NANDM = 4'hF
  } opcode_e;

`ifdef NIBBLER_SINGLE_STEP_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;
`endif

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_CMP  = 2'b11;

  // Decoded EXEC controls, all active-high.
  typedef struct packed {
    logic       load_a;
    logic       load_flags;
    logic       write_ram;
    logic       oe_in;
    logic       load_out;
    logic       src_mem;
    logic [1:0] alu_sel;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/nibbler_decoder.sv
// -----------------------------------------------------------------------------
// nibbler_decoder
// Purely combinational decode of the registered instruction plus the
// registered flags into one EXEC control word. The sequencer decides when the
// word is allowed onto the pins.
// Ports:
//   ir    in  [7:0] registered instruction, [7:4] opcode
//   flags in  [1:0] {notC, notZ}, active-low
//   ctrl  out       decoded control word (active-high)
// -----------------------------------------------------------------------------
module nibbler_decoder
  import nibbler_pkg::*;
(
  input  logic [7:0] ir,
  input  logic [1:0] flags,
  output ctrl_t      ctrl
);

  logic not_c;
  logic not_z;

  assign not_c = flags[1];
  assign not_z = flags[0];

  // NOTE: every always_comb output gets a default before the case so that an
  // unlisted path can never infer a latch.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (opcode_e'(ir[7:4]))
      OP_JC:    ctrl.jump = ~not_c;
      OP_JNC:   ctrl.jump = not_c;
      OP_CMPI: begin
        ctrl.load_flags = 1'b1;
        ctrl.alu_sel    = ALU_CMP;
      end
      OP_CMPM: begin
        ctrl.load_flags = 1'b1;
        ctrl.alu_sel    = ALU_CMP;
        ctrl.src_mem    = 1'b1;
      end
      OP_LIT:   ctrl.load_a = 1'b1;
      OP_IN: begin
        ctrl.load_a = 1'b1;
        ctrl.oe_in  = 1'b1;
      end
      OP_LD: begin
        ctrl.load_a  = 1'b1;
        ctrl.src_mem = 1'b1;
      end
      OP_ST: begin
        ctrl.write_ram = 1'b1;
        ctrl.src_mem   = 1'b1;
      end
      OP_JZ:    ctrl.jump = ~not_z;
      OP_JNZ:   ctrl.jump = not_z;
      OP_ADDI: begin
        ctrl.load_a     = 1'b1;
        ctrl.load_flags = 1'b1;
        ctrl.alu_sel    = ALU_ADD;
      end
      OP_ADDM: begin
        ctrl.load_a     = 1'b1;
        ctrl.load_flags = 1'b1;
        ctrl.alu_sel    = ALU_ADD;
        ctrl.src_mem    = 1'b1;
      end
      OP_JMP:   ctrl.jump = 1'b1;
      OP_OUT:   ctrl.load_out = 1'b1;
      OP_NANDI: begin
        ctrl.load_a     = 1'b1;
        ctrl.load_flags = 1'b1;
        ctrl.alu_sel    = ALU_NAND;
      end
      OP_NANDM: begin
        ctrl.load_a     = 1'b1;
        ctrl.load_flags = 1'b1;
        ctrl.alu_sel    = ALU_NAND;
        ctrl.src_mem    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/nibbler_sequencer.sv
// -----------------------------------------------------------------------------
// nibbler_sequencer
// Two-phase FETCH/EXEC control sequencer for the Nibbler CPU. Holds the
// instruction register and the state machine; decode is delegated to
// nibbler_decoder. Build option NIBBLER_SINGLE_STEP_EN adds a step input and a
// PAUSE state entered after every EXEC while step is low.
// Ports:
//   clk, notReset             clock, async active-low reset
//   step (option only)        high: continue past PAUSE
//   instr   [7:0]             program ROM byte
//   flagsIn [1:0]             {notC, notZ}, active-low
//   notLoadIR, notLoadPC, notLoadA, notLoadFlags,
//   notWriteRAM, notOEin, notLoadOut   active-low strobes
//   incPC                     PC increment
//   aluSel [1:0], srcMem      ALU function and B-operand source
//   operand [3:0]             IR[3:0]
//   phase                     0 FETCH/PAUSE, 1 EXEC
// -----------------------------------------------------------------------------
module nibbler_sequencer
  import nibbler_pkg::*;
(
  input  logic       clk,
  input  logic       notReset,
`ifdef NIBBLER_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instr,
  input  logic [1:0] flagsIn,
  output logic       notLoadIR,
  output logic       incPC,
  output logic       notLoadPC,
  output logic       notLoadA,
  output logic       notLoadFlags,
  output logic [1:0] aluSel,
  output logic       srcMem,
  output logic       notWriteRAM,
  output logic       notOEin,
  output logic       notLoadOut,
  output logic [3:0] operand,
  output logic       phase
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;
  logic       load_ir;
  logic       exec_active;

  nibbler_decoder u_decoder (
    .ir    (ir_q),
    .flags (flagsIn),
    .ctrl  (dec_ctrl)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q <= ST_FETCH;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic. IR only captures on the edge that leaves FETCH, so ROM
  // activity during EXEC is invisible to decode.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_EXEC;
        ir_d    = instr;
      end
`ifdef NIBBLER_SINGLE_STEP_EN
      ST_EXEC:  state_d = step ? ST_FETCH : ST_PAUSE;
      ST_PAUSE: state_d = step ? ST_FETCH : ST_PAUSE;
`else
      ST_EXEC:  state_d = ST_FETCH;
`endif
      default:  state_d = ST_FETCH;
    endcase
  end

  // Output logic. While notReset is low every strobe is forced inactive even
  // though the state already reads FETCH; this keeps the IR strobe quiet until
  // the first real edge and lets a mid-EXEC reset cut a store or load short
  // immediately rather than at the next clock.
  always_comb begin
    load_ir     = 1'b0;
    exec_active = 1'b0;
    ctrl        = CTRL_IDLE;
    if (notReset) begin
      case (state_q)
        ST_FETCH: load_ir = 1'b1;
        ST_EXEC: begin
          exec_active = 1'b1;
          ctrl        = dec_ctrl;
        end
        default: ;
      endcase
    end
  end

  // A taken jump replaces the increment, so the two PC controls are mutually
  // exclusive by construction.
  assign notLoadIR    = ~load_ir;
  assign incPC        = exec_active & ~ctrl.jump;
  assign notLoadPC    = ~(exec_active & ctrl.jump);
  assign notLoadA     = ~ctrl.load_a;
  assign notLoadFlags = ~ctrl.load_flags;
  assign aluSel       = ctrl.alu_sel;
  assign srcMem       = ctrl.src_mem;
  assign notWriteRAM  = ~ctrl.write_ram;
  assign notOEin      = ~ctrl.oe_in;
  assign notLoadOut   = ~ctrl.load_out;
  assign operand      = ir_q[3:0];
  assign phase        = (state_q == ST_EXEC);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nibbler_sequencer
// Self-checking bench for nibbler_sequencer. A small reference model tracks
// whether the CPU is fetching, executing or paused and which byte it holds, and
// derives every expected output from opcode membership tables. Inputs change
// on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_nibbler_sequencer;

  logic       clk = 1'b0;
  logic       notReset;
  logic [7:0] instr;
  logic [1:0] flagsIn;
  logic       step_v;
  logic       notLoadIR, incPC, notLoadPC, notLoadA, notLoadFlags;
  logic [1:0] aluSel;
  logic       srcMem, notWriteRAM, notOEin, notLoadOut;
  logic [3:0] operand;
  logic       phase;

`ifdef NIBBLER_SINGLE_STEP_EN
  logic step;
  assign step = step_v;
`endif

  always #5 clk = ~clk;

  nibbler_sequencer dut (
    .clk          (clk),
    .notReset     (notReset),
`ifdef NIBBLER_SINGLE_STEP_EN
    .step         (step),
`endif
    .instr        (instr),
    .flagsIn      (flagsIn),
    .notLoadIR    (notLoadIR),
    .incPC        (incPC),
    .notLoadPC    (notLoadPC),
    .notLoadA     (notLoadA),
    .notLoadFlags (notLoadFlags),
    .aluSel       (aluSel),
    .srcMem       (srcMem),
    .notWriteRAM  (notWriteRAM),
    .notOEin      (notOEin),
    .notLoadOut   (notLoadOut),
    .operand      (operand),
    .phase        (phase)
  );

  // All outputs packed into one word for whole-cycle comparisons.
  logic [15:0] act_word;
  assign act_word = {notLoadIR, incPC, notLoadPC, notLoadA, notLoadFlags,
                     aluSel, srcMem, notWriteRAM, notOEin, notLoadOut,
                     operand, phase};

  // Opcode membership tables, bit n set when opcode n has the property.
  localparam logic [15:0] LOAD_A_OPS = 16'b1100_1100_0111_0000;
  localparam logic [15:0] FLAG_OPS   = 16'b1100_1100_0000_1100;
  localparam logic [15:0] MEM_OPS    = 16'b1000_1000_1100_1000;

  // Reference model state.
  logic       m_fetch;
  logic       m_pause;
  logic [7:0] m_ir;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic in_rst, input logic fetching,
                                           input logic paused, input logic [7:0] ir,
                                           input logic [1:0] fl);
    logic [3:0] op;
    logic       taken;
    logic       flag;
    logic [1:0] alu;
    op = ir[7:4];
    if (in_rst)
      return {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0};
    if (paused)
      return {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, ir[3:0], 1'b0};
    if (fetching)
      return {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, ir[3:0], 1'b0};
    // Conditional jumps: 0/1 test notC, 8/9 test notZ; even opcodes jump on a
    // low flag, odd ones on a high flag.
    flag  = op[3] ? fl[0] : fl[1];
    taken = 1'b0;
    if (op == 4'hC) taken = 1'b1;
    else if (op == 4'h0 || op == 4'h1 || op == 4'h8 || op == 4'h9) taken = (flag == op[0]);
    alu = 2'b00;
    if (op == 4'hA || op == 4'hB) alu = 2'b01;
    else if (op == 4'hE || op == 4'hF) alu = 2'b10;
    else if (op == 4'h2 || op == 4'h3) alu = 2'b11;
    return {1'b1, ~taken, ~taken, ~LOAD_A_OPS[op], ~FLAG_OPS[op], alu, MEM_OPS[op],
            ~(op == 4'h7), ~(op == 4'h5), ~(op == 4'hD), ir[3:0], 1'b1};
  endfunction

  task automatic drive_and_check(input logic [7:0] ins, input logic [1:0] fl, input string tag);
    @(negedge clk);
    instr   = ins;
    flagsIn = fl;
    #1;
    check(tag, act_word, exp_word(1'b0, m_fetch, m_pause, m_ir, fl));
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_pause) begin
      if (step_v) begin m_pause = 1'b0; m_fetch = 1'b1; end
    end else if (m_fetch) begin
      m_ir    = instr;
      m_fetch = 1'b0;
    end else if (step_v) begin
      m_fetch = 1'b1;
    end else begin
      m_pause = 1'b1;
    end
  endtask

  task automatic run_cycle(input logic [7:0] ins, input logic [1:0] fl, input string tag);
    drive_and_check(ins, fl, tag);
    advance();
  endtask

  // Pulse reset between a falling-edge sample and the next rising edge, then
  // confirm a clean FETCH before that edge arrives.
  task automatic mid_reset(input logic [7:0] next_ins, input string tag);
    #1;
    notReset = 1'b0;
    m_fetch  = 1'b1;
    m_pause  = 1'b0;
    m_ir     = 8'h00;
    #1;
    check({tag, "_in_rst"}, act_word, exp_word(1'b1, 1'b1, 1'b0, 8'h00, flagsIn));
    instr    = next_ins;
    notReset = 1'b1;
    #1;
    check({tag, "_post_rst"}, act_word, exp_word(1'b0, 1'b1, 1'b0, 8'h00, flagsIn));
    advance();
  endtask

  initial begin
    notReset = 1'b0;
    instr    = 8'h00;
    flagsIn  = 2'b11;
    step_v   = 1'b1;
    m_fetch  = 1'b1;
    m_pause  = 1'b0;
    m_ir     = 8'h00;

    // Reset holds outputs inactive even with the clock running.
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", act_word, exp_word(1'b1, 1'b1, 1'b0, 8'h00, flagsIn));

    // LIT 7 straight out of reset: first edge fetches, next cycle executes.
    @(negedge clk);
    instr    = 8'h47;
    notReset = 1'b1;
    #1;
    check("first_fetch", act_word, exp_word(1'b0, 1'b1, 1'b0, 8'h00, flagsIn));
    advance();
    drive_and_check(8'h47, 2'b11, "lit_exec");
    check("lit_notLoadA", {15'd0, notLoadA}, 16'd0);
    check("lit_aluSel", {14'd0, aluSel}, 16'd0);
    check("lit_operand", {12'd0, operand}, 16'd7);
    check("lit_incPC", {15'd0, incPC}, 16'd1);
    advance();

    // ADDI then JC, once taken (notC low) and once not taken.
    run_cycle(8'hA3, 2'b11, "addi_fetch");
    run_cycle(8'h00, 2'b11, "addi_exec");
    run_cycle(8'h05, 2'b01, "jc_fetch");
    drive_and_check(8'h00, 2'b01, "jc_taken");
    check("jc_taken_notLoadPC", {15'd0, notLoadPC}, 16'd0);
    check("jc_taken_incPC", {15'd0, incPC}, 16'd0);
    advance();
    run_cycle(8'h05, 2'b11, "jc2_fetch");
    run_cycle(8'h00, 2'b11, "jc_not_taken");

    // CMPM: flags strobe for exactly one cycle, accumulator untouched.
    run_cycle(8'h35, 2'b11, "cmpm_fetch");
    run_cycle(8'h00, 2'b11, "cmpm_exec");
    run_cycle(8'h40, 2'b11, "cmpm_after");
    run_cycle(8'h00, 2'b11, "lit0_exec");

    // ST aborted by reset mid-EXEC; LIT follows so a replayed store would show.
    run_cycle(8'h72, 2'b11, "st_fetch");
    drive_and_check(8'h00, 2'b11, "st_exec");
    mid_reset(8'h40, "st_abort");
    drive_and_check(8'h00, 2'b11, "after_abort_exec");
    check("after_abort_notWriteRAM", {15'd0, notWriteRAM}, 16'd1);
    advance();

    // ROM byte changes under EXEC must not leak into decode.
    run_cycle(8'h4F, 2'b11, "ir_hold_fetch");
    run_cycle(8'hD0, 2'b11, "ir_hold_exec");

`ifdef NIBBLER_SINGLE_STEP_EN
    // Single step: park in PAUSE for five cycles, then resume.
    run_cycle(8'hB2, 2'b11, "step_fetch");
    step_v = 1'b0;
    run_cycle(8'h00, 2'b11, "step_exec");
    for (int i = 0; i < 5; i++) run_cycle(8'h00, 2'b11, "pause_hold");
    step_v = 1'b1;
    run_cycle(8'h00, 2'b11, "pause_release");
    run_cycle(8'h99, 2'b10, "resume_fetch");
`endif

    // Random program bytes, flags and occasional resets.
    for (int i = 0; i < 400; i++) begin
`ifdef NIBBLER_SINGLE_STEP_EN
      step_v = ($urandom_range(0, 3) != 0);
`endif
      drive_and_check(8'($urandom), 2'($urandom), "random");
      if ($urandom_range(0, 39) == 0)
        mid_reset(8'($urandom), "random_reset");
      else
        advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
